// File: rtl/pipe_hazard_ctrl.sv
// Decode-stage hazard controller: operand forwarding selects, load-use stall,
// and sequencing of the multi-cycle multiply/divide unit.
module pipe_hazard_ctrl #(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        id_valid,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_use_rs,
  input  logic        id_use_rt,
  input  logic [1:0]  id_md_op,
  input  logic        exe_wreg,
  input  logic        exe_m2reg,
  input  logic [4:0]  exe_rn,
  input  logic        mem_wreg,
  input  logic        mem_m2reg,
  input  logic [4:0]  mem_rn,
  output logic [1:0]  fwda,
  output logic [1:0]  fwdb,
  output logic        wpcir,
  output logic        bubble,
  output logic        md_start,
  output logic        md_is_div,
  output logic        md_busy,
  output logic [15:0] stall_cycles
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;
  localparam logic [5:0] MUL_LOAD = 6'(MUL_CYCLES - 1);
  localparam logic [5:0] DIV_LOAD = 6'(DIV_CYCLES - 1);

  logic [0:0]  r_state;
  logic [5:0]  r_cnt;
  logic [15:0] r_stall_cycles;

  logic w_load_use;
  logic w_md_conflict;
  logic w_stall;
  logic w_md_req;

  // A load in EXE has no data yet, so it is never an EXE forward source.
  function automatic logic [1:0] fwd_sel(input logic [4:0] src);
    logic [1:0] sel;
    sel = 2'b00;
    if (exe_wreg && exe_rn != 5'd0 && exe_rn == src && !exe_m2reg)
      sel = 2'b01;
    else if (mem_wreg && mem_rn != 5'd0 && mem_rn == src)
      sel = mem_m2reg ? 2'b11 : 2'b10;
    return sel;
  endfunction

  assign fwda = fwd_sel(id_rs);
  assign fwdb = fwd_sel(id_rt);

  assign w_load_use = id_valid && exe_wreg && exe_m2reg && exe_rn != 5'd0 &&
                      ((id_use_rs && id_rs == exe_rn) || (id_use_rt && id_rt == exe_rn));
  assign md_busy       = (r_state == ST_BUSY);
  assign w_md_conflict = id_valid && id_md_op != 2'b00 && md_busy;
  assign w_stall       = w_load_use || w_md_conflict;

  assign wpcir  = !w_stall;
  assign bubble = w_stall;

  assign w_md_req  = id_valid && (id_md_op == 2'b01 || id_md_op == 2'b10);
  assign md_start  = (r_state == ST_IDLE) && w_md_req && !w_stall;
  assign md_is_div = (id_md_op == 2'b10);

  // Counter holds remaining busy cycles minus one; BUSY lasts exactly N cycles.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
      r_cnt   <= 6'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (md_start) begin
            r_state <= ST_BUSY;
            r_cnt   <= md_is_div ? DIV_LOAD : MUL_LOAD;
          end
        end
        default: begin
          if (r_cnt == 6'd0) begin
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt - 6'd1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_stall_cycles <= 16'd0;
    end else if (w_stall && r_stall_cycles != 16'hFFFF) begin
      r_stall_cycles <= r_stall_cycles + 16'd1;
    end
  end

  assign stall_cycles = r_stall_cycles;

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Hazard and sequencing controller for the decode stage of the five-stage pipeline. It compares decode-stage source registers against in-flight EXE/MEM destinations and produces forwarding selects for the decode operand muxes. It detects load-use hazards and stalls PC/IF-ID while inserting a bubble into ID/EXE. It also sequences the multi-cycle multiply/divide unit, stalling dependent or conflicting HI/LO instructions until the unit finishes.

## Interface
Parameters:
- MUL_CYCLES, 4, busy cycles for mult/multu (1..63)
- DIV_CYCLES, 32, busy cycles for div/divu (1..63)

Ports:
- clock  in  1  pipeline clock, rising edge
- resetn  in  1  asynchronous, active-low reset
- id_valid  in  1  decode slot holds a live instruction (0 after flush)
- id_rs, id_rt  in  5  decode source register numbers
- id_use_rs, id_use_rt  in  1  instruction actually reads rs / rt
- id_md_op  in  2  00 none, 01 mult, 10 div, 11 mfhi/mflo/mthi/mtlo
- exe_wreg, exe_m2reg  in  1  EXE instruction writes regfile / is a load
- exe_rn  in  5  EXE destination register
- mem_wreg, mem_m2reg  in  1  MEM instruction writes regfile / is a load
- mem_rn  in  5  MEM destination register
- fwda, fwdb  out  2  operand select: 00 regfile, 01 EXE ALU result, 10 MEM ALU result, 11 MEM load data
- wpcir  out  1  PC and IF/ID write enable; 0 = stall
- bubble  out  1  force ID/EXE control signals to nop
- md_start  out  1  one-cycle start to mul/div unit
- md_is_div  out  1  qualifies md_start: 1 = divide
- md_busy  out  1  mul/div unit occupied
- stall_cycles  out  16  saturating count of stalled cycles

## Operation
- Forwarding for each source (rs→fwda, rt→fwdb) is combinational:
  - EXE match (exe_wreg, exe_rn≠0, exe_rn==src, !exe_m2reg) → 01.
  - Otherwise, MEM match (mem_wreg, mem_rn≠0, mem_rn==src) → 11 if mem_m2reg, else 10.
  - Otherwise → 00.
  - EXE has priority over MEM. Register 0 is never forwarded.
- Load-use hazard: id_valid, exe_wreg, exe_m2reg, exe_rn≠0, and (id_use_rs and id_rs==exe_rn, or id_use_rt and id_rt==exe_rn).
- md_conflict: id_valid, id_md_op≠00, md_busy.
- stall = load_use OR md_conflict. Then wpcir = !stall and bubble = stall.
- md FSM states:
  - IDLE: md_start = id_valid & (id_md_op==01 or 10) & !stall. md_is_div = (id_md_op==10). On the edge where md_start=1, load cnt with MUL_CYCLES-1 or DIV_CYCLES-1 and go to BUSY.
  - BUSY: md_busy=1 and md_start=0. Decrement cnt each cycle. When cnt==0, return to IDLE on the next edge.
- Non-HI/LO instructions proceed freely while BUSY.
- stall_cycles increments on every edge with wpcir=0 and holds at 16'hFFFF.
- id_valid=0 suppresses stall, bubble and md_start; forwarding outputs are still driven.

## Timing
- Reset values: FSM IDLE, cnt 0, md_busy 0, md_start 0, wpcir 1, bubble 0, stall_cycles 0. The forwarding outputs follow their inputs combinationally.
- Reset asserted mid-BUSY: the FSM returns to IDLE immediately (asynchronously), and any in-flight multiply/divide is abandoned.
- md_busy is high for exactly N cycles after the accept edge, where N = MUL_CYCLES or DIV_CYCLES. An instruction with id_md_op≠00 held in ID proceeds in the first cycle md_busy=0.
- Back-to-back mult then mult: the second instruction stalls N cycles and then starts. There is no gap cycle beyond that.
- Load-use stall lasts exactly 1 cycle. After that, the load is in MEM and the operand select becomes 11.
- Load-use and md_conflict in the same cycle give a single stall. The stall counter counts that cycle once.
- mult in ID with a load-use hazard: md_start=0 that cycle and the FSM stays IDLE. md_start is asserted on the following cycle.
- All outputs other than md_busy and stall_cycles are combinational from inputs and state. The FSM advances only on clock edges.

## Test plan
- Reset: resetn=0 during BUSY with cnt=10 → md_busy=0 immediately. After release: wpcir=1, stall_cycles=0.
- Forwarding:
  - exe_rn=mem_rn=5, both wreg, exe_m2reg=0, id_rs=5 → fwda=01.
  - Same with exe_wreg=0, mem_m2reg=1 → fwda=11.
  - id_rs=0 with exe_rn=0 → fwda=00.
- Load-use: exe lw $3, id add using rt=$3 → wpcir=0 and bubble=1 for one cycle, then fwdb=11, wpcir=1, stall_cycles=1.
- div (DIV_CYCLES=32) followed by mfhi → md_start=1 with md_is_div=1, then mfhi stalls 32 cycles. mfhi proceeds on cycle 33 with md_busy=0, and stall_cycles=32.
- Independent instructions during mult BUSY: add/sw stream never stalls while md_busy=1 for 4 cycles. With id_valid=0 and id_md_op=01, no md_start is issued.
- Saturation: force 70000 stall cycles → stall_cycles holds at 16'hFFFF.
